// File: rtl/wm_block_scheduler.sv
// ---------------------------------------------------------------------------
// wm_block_scheduler
//
// Read-side sequencer for the watermarking register bank. On a rising START
// level it takes the bank port, reads the geometry registers (Np, Nw, M),
// validates them, then walks the primary image in MxM blocks (raster order
// inside each block, blocks clipped at the image edges). For every pixel it
// fetches the primary datum and, when WM_FETCH_EN is defined, the matching
// watermark datum, and presents them on a valid/ready stream with block
// markers. The bank is only ever read.
//
// Optional feature macro: WM_FETCH_EN
//   defined   : FETCH_W state present, watermark pixel fetched onto wm_data,
//               configuration also rejected when Nw != Np.
//   undefined : FETCH_P goes straight to CAPT, wm_data is 0, Nw ignored.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      bank START bit (level)
//   bus_req    scheduler owns the bank port
//   bus_ctrl   bank CTRL, always 0 (read)
//   bus_addr   bank read address
//   bus_rdata  bank read data, valid the cycle after its address
//   pix_valid  / pix_ready    pixel stream handshake
//   pix_data   primary pixel
//   wm_data    watermark pixel
//   pix_row / pix_col         absolute pixel coordinates
//   blk_first / blk_last      first / last beat of the current block
//   img_last   final beat of the image
//   busy       a scan is in progress
//   done       one-cycle completion pulse
//   err        configuration error, sticky until start=0
// ---------------------------------------------------------------------------
module wm_block_scheduler #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       bus_req,
  output logic                       bus_ctrl,
  output logic [Amba_Addr_Depth-1:0] bus_addr,
  input  logic [Amba_Word-1:0]       bus_rdata,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [Amba_Word-1:0]       pix_data,
  output logic [Amba_Word-1:0]       wm_data,
  output logic [Amba_Word-1:0]       pix_row,
  output logic [Amba_Word-1:0]       pix_col,
  output logic                       blk_first,
  output logic                       blk_last,
  output logic                       img_last,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int AW = Amba_Word;
  localparam int AD = Amba_Addr_Depth;

  localparam logic [AD-1:0] ADDR_NP  = AD'(2);
  localparam logic [AD-1:0] ADDR_NW  = AD'(3);
  localparam logic [AD-1:0] ADDR_M   = AD'(4);
  localparam logic [AD-1:0] ADDR_PIX = AD'(10);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_CHECK,
    S_FETCH_P,
`ifdef WM_FETCH_EN
    S_FETCH_W,
`endif
    S_CAPT,
    S_OUT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q;
  logic [1:0]      cfg_cnt_q;
  logic [AW-1:0]   np_q;
  logic [AW-1:0]   m_q;
`ifdef WM_FETCH_EN
  logic [AW-1:0]   nw_q;
  logic [AD-1:0]   np_sq_q;
  logic [AW-1:0]   prim_q;
`endif

  // Scan position: block origin (br, bc), offset inside block (r, c).
  // row_base_q = (br + r) * Np, blk_base_q = br * Np; both kept incrementally.
  logic [AW-1:0]   br_q, bc_q, r_q, c_q;
  logic [AD-1:0]   row_base_q, blk_base_q;

  // Registered outputs
  logic            bus_req_q;
  logic [AD-1:0]   bus_addr_q;
  logic            pix_valid_q;
  logic [AW-1:0]   pix_data_q, wm_data_q, pix_row_q, pix_col_q;
  logic            blk_first_q, blk_last_q, img_last_q;
  logic            busy_q, done_q, err_q;

  // -------------------------------------------------------------------------
  // Geometry of the current (possibly clipped) block
  // -------------------------------------------------------------------------
  logic [AW-1:0]   rows_left, cols_left, blk_h, blk_w;
  logic [AW:0]     br_step, bc_step;
  logic            col_end, row_end, last_bcol, last_brow;
  logic [AD-1:0]   np_ext;
  logic            cfg_bad;

  assign np_ext    = AD'(np_q);
  assign rows_left = np_q - br_q;
  assign cols_left = np_q - bc_q;
  assign blk_h     = (m_q < rows_left) ? m_q : rows_left;
  assign blk_w     = (m_q < cols_left) ? m_q : cols_left;
  assign col_end   = (c_q == blk_w - AW'(1));
  assign row_end   = (r_q == blk_h - AW'(1));
  // 17-bit sums so an origin stepping past 0xFFFF is still seen as "beyond Np"
  assign br_step   = {1'b0, br_q} + {1'b0, m_q};
  assign bc_step   = {1'b0, bc_q} + {1'b0, m_q};
  assign last_bcol = (bc_step >= {1'b0, np_q});
  assign last_brow = (br_step >= {1'b0, np_q});

  always_comb begin
    cfg_bad = (np_q == '0) || (m_q == '0) || (m_q > np_q);
`ifdef WM_FETCH_EN
    if (nw_q != np_q) cfg_bad = 1'b1;
`endif
  end

  // -------------------------------------------------------------------------
  // Next scan position after the current pixel (used on the OUT handshake)
  // -------------------------------------------------------------------------
  logic [AW-1:0]   nxt_br, nxt_bc, nxt_r, nxt_c, nxt_col;
  logic [AD-1:0]   nxt_rb, nxt_blk, nxt_paddr;

  always_comb begin
    nxt_br  = br_q;
    nxt_bc  = bc_q;
    nxt_r   = r_q;
    nxt_c   = c_q + AW'(1);
    nxt_rb  = row_base_q;
    nxt_blk = blk_base_q;
    if (col_end) begin
      nxt_c = '0;
      if (!row_end) begin
        nxt_r  = r_q + AW'(1);
        nxt_rb = row_base_q + np_ext;
      end else begin
        nxt_r = '0;
        if (!last_bcol) begin
          // Next block to the right: back to the block's first row.
          nxt_bc = bc_step[AW-1:0];
          nxt_rb = blk_base_q;
        end else begin
          // Next block row. The block just finished was full height, so the
          // row after its last row is exactly br + M.
          nxt_bc  = '0;
          nxt_br  = br_step[AW-1:0];
          nxt_rb  = row_base_q + np_ext;
          nxt_blk = row_base_q + np_ext;
        end
      end
    end
    nxt_col   = nxt_bc + nxt_c;
    nxt_paddr = ADDR_PIX + nxt_rb + AD'(nxt_col);
  end

  // -------------------------------------------------------------------------
  // FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cfg_cnt_q   <= '0;
      np_q        <= '0;
      m_q         <= '0;
`ifdef WM_FETCH_EN
      nw_q        <= '0;
      np_sq_q     <= '0;
      prim_q      <= '0;
`endif
      br_q        <= '0;
      bc_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
      row_base_q  <= '0;
      blk_base_q  <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      wm_data_q   <= '0;
      pix_row_q   <= '0;
      pix_col_q   <= '0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
      img_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!start && !(state_q inside {S_IDLE, S_DONE, S_ERR})) begin
        // Abort: the only case where pix_valid drops without a handshake.
        state_q     <= S_IDLE;
        bus_req_q   <= 1'b0;
        busy_q      <= 1'b0;
        pix_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            err_q <= 1'b0;
            if (start) begin
              state_q    <= S_CFG;
              cfg_cnt_q  <= '0;
              bus_addr_q <= ADDR_NP;
              bus_req_q  <= 1'b1;
              busy_q     <= 1'b1;
            end
          end

          // Address k is on the bus in CFG cycle k; its data is captured at
          // the end of cycle k+1.
          S_CFG: begin
            cfg_cnt_q <= cfg_cnt_q + 2'd1;
            case (cfg_cnt_q)
              2'd0: bus_addr_q <= ADDR_NW;
              2'd1: begin
                np_q       <= bus_rdata;
                bus_addr_q <= ADDR_M;
              end
              2'd2: begin
`ifdef WM_FETCH_EN
                nw_q <= bus_rdata;
`endif
              end
              2'd3: begin
                m_q     <= bus_rdata;
                state_q <= S_CHECK;
              end
            endcase
          end

          S_CHECK: begin
            if (cfg_bad) begin
              state_q   <= S_ERR;
              err_q     <= 1'b1;
              bus_req_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
`ifdef WM_FETCH_EN
              np_sq_q    <= np_ext * np_ext;
`endif
              br_q       <= '0;
              bc_q       <= '0;
              r_q        <= '0;
              c_q        <= '0;
              row_base_q <= '0;
              blk_base_q <= '0;
              bus_addr_q <= ADDR_PIX;
              state_q    <= S_FETCH_P;
            end
          end

          S_FETCH_P: begin
`ifdef WM_FETCH_EN
            // Watermark pixel sits Np^2 words past the primary one.
            bus_addr_q <= bus_addr_q + np_sq_q;
            state_q    <= S_FETCH_W;
`else
            state_q    <= S_CAPT;
`endif
          end

`ifdef WM_FETCH_EN
          S_FETCH_W: begin
            prim_q  <= bus_rdata;
            state_q <= S_CAPT;
          end
`endif

          S_CAPT: begin
`ifdef WM_FETCH_EN
            pix_data_q <= prim_q;
            wm_data_q  <= bus_rdata;
`else
            pix_data_q <= bus_rdata;
            wm_data_q  <= '0;
`endif
            pix_row_q   <= br_q + r_q;
            pix_col_q   <= bc_q + c_q;
            blk_first_q <= (r_q == '0) && (c_q == '0);
            blk_last_q  <= row_end && col_end;
            img_last_q  <= row_end && col_end && last_bcol && last_brow;
            pix_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end

          S_OUT: begin
            if (pix_ready) begin
              pix_valid_q <= 1'b0;
              if (img_last_q) begin
                state_q   <= S_DONE;
                done_q    <= 1'b1;
                bus_req_q <= 1'b0;
                busy_q    <= 1'b0;
              end else begin
                br_q       <= nxt_br;
                bc_q       <= nxt_bc;
                r_q        <= nxt_r;
                c_q        <= nxt_c;
                row_base_q <= nxt_rb;
                blk_base_q <= nxt_blk;
                bus_addr_q <= nxt_paddr;
                state_q    <= S_FETCH_P;
              end
            end
          end

          // No auto-restart: START must be seen low before a new scan.
          S_DONE: begin
            if (!start) state_q <= S_IDLE;
          end

          S_ERR: begin
            if (!start) begin
              state_q <= S_IDLE;
              err_q   <= 1'b0;
            end
          end

          default: begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            pix_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_ctrl  = 1'b0;
  assign bus_addr  = bus_addr_q;
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign wm_data   = wm_data_q;
  assign pix_row   = pix_row_q;
  assign pix_col   = pix_col_q;
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;
  assign img_last  = img_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wm_block_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for wm_block_scheduler: behavioural bank memory, scoreboard of
// expected beats built from nested block loops, one task per scenario.
// ---------------------------------------------------------------------------
module tb_wm_block_scheduler;

  localparam int AW = 16;
  localparam int AD = 20;
`ifdef WM_FETCH_EN
  localparam int BEAT_CYC = 4;
  localparam bit WM_ON    = 1'b1;
`else
  localparam int BEAT_CYC = 3;
  localparam bit WM_ON    = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          bus_req;
  logic          bus_ctrl;
  logic [AD-1:0] bus_addr;
  logic [AW-1:0] bus_rdata;
  logic          pix_valid;
  logic          pix_ready;
  logic [AW-1:0] pix_data, wm_data, pix_row, pix_col;
  logic          blk_first, blk_last, img_last;
  logic          busy, done, err;

  wm_block_scheduler #(.Amba_Word(AW), .Amba_Addr_Depth(AD)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bus_req(bus_req), .bus_ctrl(bus_ctrl), .bus_addr(bus_addr), .bus_rdata(bus_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .wm_data(wm_data), .pix_row(pix_row), .pix_col(pix_col),
    .blk_first(blk_first), .blk_last(blk_last), .img_last(img_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Bank model: read data appears the cycle after the address.
  logic [AW-1:0] mem [0:255];
  always @(posedge clk)
    bus_rdata <= (bus_addr < AD'(256)) ? mem[bus_addr[7:0]] : 16'hDEAD;

  typedef struct packed {
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [AW-1:0] pix;
    logic [AW-1:0] wm;
    logic          first;
    logic          last;
    logic          ilast;
  } beat_t;

  beat_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Fill the bank and push the expected beat sequence for this geometry.
  task automatic load_image(input int np, input int nw, input int m);
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 41 + 16'h0500);
    mem[2] = 16'(np);
    mem[3] = 16'(nw);
    mem[4] = 16'(m);
    sb_q.delete();
    if (np > 0 && m > 0 && m <= np && (!WM_ON || nw == np)) begin
      for (int br = 0; br < np; br += m) begin
        for (int bc = 0; bc < np; bc += m) begin
          int bh, bw;
          bh = (np - br < m) ? np - br : m;
          bw = (np - bc < m) ? np - bc : m;
          for (int r = 0; r < bh; r++) begin
            for (int c = 0; c < bw; c++) begin
              beat_t b;
              int row, col;
              row     = br + r;
              col     = bc + c;
              b.row   = 16'(row);
              b.col   = 16'(col);
              b.pix   = mem[10 + row * np + col];
              b.wm    = WM_ON ? mem[10 + np * np + row * np + col] : 16'h0;
              b.first = (r == 0 && c == 0);
              b.last  = (r == bh - 1 && c == bw - 1);
              b.ilast = (row == np - 1 && col == np - 1);
              sb_q.push_back(b);
            end
          end
        end
      end
    end
  endtask

  task automatic stop_image();
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Pops and compares beats as handshakes occur; optionally stalls one beat.
  task automatic consume_beats(input int max_beats, input int stall_beat,
                               input int budget, output int got);
    int    cyc;
    int    last_hs;
    beat_t exp_b, got_b, snap;
    logic [AD-1:0] snap_addr;
    cyc     = 0;
    last_hs = -1;
    got     = 0;
    while (sb_q.size() > 0 && got < max_beats && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (pix_valid && got == stall_beat) begin
        snap      = {pix_row, pix_col, pix_data, wm_data, blk_first, blk_last, img_last};
        snap_addr = bus_addr;
        pix_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
          @(negedge clk);
          cyc++;
          got_b = {pix_row, pix_col, pix_data, wm_data, blk_first, blk_last, img_last};
          n_tests++;
          if (got_b !== snap || pix_valid !== 1'b1 || bus_addr !== snap_addr) begin
            n_fail++;
            $display("FAIL stall_hold cycle %0d: valid=%b addr=%h beat=%h, required valid=1 addr=%h beat=%h",
                     k, pix_valid, bus_addr, got_b, snap_addr, snap);
          end
        end
        pix_ready = 1'b1;
      end
      if (pix_valid && pix_ready) begin
        got_b = {pix_row, pix_col, pix_data, wm_data, blk_first, blk_last, img_last};
        exp_b = sb_q.pop_front();
        n_tests++;
        if (got_b !== exp_b) begin
          n_fail++;
          $display("FAIL beat%0d: got (%0d,%0d) pix=%h wm=%h f/l/il=%b%b%b, required (%0d,%0d) pix=%h wm=%h f/l/il=%b%b%b",
                   got, got_b.row, got_b.col, got_b.pix, got_b.wm, got_b.first, got_b.last, got_b.ilast,
                   exp_b.row, exp_b.col, exp_b.pix, exp_b.wm, exp_b.first, exp_b.last, exp_b.ilast);
        end
        if (stall_beat < 0 && last_hs >= 0) begin
          n_tests++;
          if (cyc - last_hs != BEAT_CYC) begin
            n_fail++;
            $display("FAIL beat_interval beat%0d: %0d cycles, required %0d", got, cyc - last_hs, BEAT_CYC);
          end
        end
        last_hs = cyc;
        got++;
      end
    end
    if (got < max_beats && sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d beats received, %0d still expected", got, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    start     = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus_req, bus_ctrl, bus_addr, pix_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: req=%b ctrl=%b addr=%h valid=%b, required all 0", bus_req, bus_ctrl, bus_addr, pix_valid);
    end
    n_tests++;
    if ({pix_data, wm_data, pix_row, pix_col, blk_first, blk_last, img_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h wm=%h row=%h col=%h markers=%b%b%b, required all 0",
               pix_data, wm_data, pix_row, pix_col, blk_first, blk_last, img_last);
    end
    n_tests++;
    if ({busy, done, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: busy/done/err=%b%b%b, required 000", busy, done, err);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int got;
    $display("[TB] basic Np=4 M=2");
    load_image(4, 4, 2);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus_addr !== AD'(2 + k) || bus_req !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL cfg_addr%0d: addr=%h req=%b busy=%b, required addr=%h req=1 busy=1",
                 k, bus_addr, bus_req, busy, 2 + k);
      end
    end
    consume_beats(100, -1, 300, got);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b valid=%b, required 1 0 0", done, busy, pix_valid);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: done=%b, required 0", done);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || pix_valid !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL no_restart: busy=%b valid=%b req=%b, required 0 0 0", busy, pix_valid, bus_req);
    end
    stop_image();
  endtask

  task automatic test_partial();
    int got;
    $display("[TB] partial blocks Np=5 M=2");
    load_image(5, WM_ON ? 5 : 0, 2);
    start = 1'b1;
    consume_beats(100, -1, 400, got);
    n_tests++;
    if (got != 25) begin
      n_fail++;
      $display("FAIL partial_count: %0d beats, required 25", got);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_done: done=%b, required 1", done);
    end
    stop_image();
  endtask

  task automatic test_backpressure();
    int got;
    $display("[TB] backpressure on beat 3");
    load_image(4, 4, 2);
    start = 1'b1;
    consume_beats(100, 3, 400, got);
    n_tests++;
    if (got != 16) begin
      n_fail++;
      $display("FAIL bp_count: %0d beats, required 16", got);
    end
    stop_image();
  endtask

  task automatic test_err();
    int bad_m[2] = '{0, 6};
    int vcnt;
    for (int i = 0; i < 2; i++) begin
      $display("[TB] config error Np=4 M=%0d", bad_m[i]);
      load_image(4, 4, bad_m[i]);
      start = 1'b1;
      vcnt  = 0;
      for (int k = 0; k < 20 && err !== 1'b1; k++) begin
        @(negedge clk);
        if (pix_valid) vcnt++;
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (err !== 1'b1 || vcnt != 0 || busy !== 1'b0 || bus_req !== 1'b0) begin
        n_fail++;
        $display("FAIL err_set M=%0d: err=%b beats=%0d busy=%b req=%b, required err=1 beats=0 busy=0 req=0",
                 bad_m[i], err, vcnt, busy, bus_req);
      end
      start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_clear M=%0d: err=%b busy=%b, required 0 0", bad_m[i], err, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int got;
    $display("[TB] abort mid-image and rescan");
    load_image(4, 4, 2);
    start = 1'b1;
    consume_beats(5, -1, 200, got);
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: valid=%b busy=%b req=%b, required 0 0 0", pix_valid, busy, bus_req);
    end
    load_image(4, 4, 2);
    start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_addr !== AD'(2) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rescan_cfg: addr=%h busy=%b, required addr=2 busy=1", bus_addr, busy);
    end
    consume_beats(100, -1, 300, got);
    n_tests++;
    if (got != 16) begin
      n_fail++;
      $display("FAIL rescan_count: %0d beats, required 16", got);
    end
    stop_image();
  endtask

`ifdef WM_FETCH_EN
  task automatic test_wm();
    int got;
    $display("[TB] watermark fetch Np=Nw=3");
    load_image(3, 3, 2);
    start = 1'b1;
    consume_beats(100, -1, 300, got);
    n_tests++;
    if (got != 9) begin
      n_fail++;
      $display("FAIL wm_count: %0d beats, required 9", got);
    end
    stop_image();
    load_image(3, 4, 2);
    start = 1'b1;
    for (int k = 0; k < 20 && err !== 1'b1; k++) @(negedge clk);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL wm_nw_err: err=%b, required 1", err);
    end
    stop_image();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_err();
    test_abort();
`ifdef WM_FETCH_EN
    test_wm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
